// File: rtl/seg_cmd_ctrl.sv
// Purpose : parse opcode/payload SPI byte frames and commit them atomically to the 4-digit display; local BCD seconds counter.
// Latency : a commit or tick increment appears on the outputs 1 clk after the final byte / tick_1s cycle.
// Backpressure: none. Every rx_valid byte seen while cs_n is low is consumed; stalls mid-command end in a TIMEOUT abort.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rx_valid, rx_byte   byte strobe and data from the SPI slave
//   cs_n                synchronized chip select (high = no frame)
//   tick_1s             one-cycle pulse per second (counter mode only)
//   digit0..digit3      display nibbles, digit0 is least significant
//   colon               00 colon, 01 decimal point, 11 none
//   count_mode          0 host mode, 1 local counter mode
//   busy                command partially received
//   frame_err           one-cycle pulse on abort or illegal opcode
module seg_cmd_ctrl #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       cs_n,
    input  logic       tick_1s,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic       count_mode,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAY1,
        S_PAY2,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;        // low two bits of the opcode: 1 digits, 2 colon, 3 mode
    logic [7:0]  r_p1;        // shadow for the first SET_DIGITS payload byte
    logic [15:0] r_tmo;
    logic [15:0] r_digits;
    logic [1:0]  r_colon;
    logic        r_mode;
    logic        r_ferr;

    logic        w_acc;
    logic        w_busy;
    logic        w_tmo;
    logic        w_dig_commit;
    logic [15:0] w_tick_val;

    // Increment as a 4-digit BCD counter. A nibble above 9 behaves as 9,
    // so it rolls to 0 and carries; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] d);
        logic [15:0] res;
        logic        carry;
        res   = d;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (d[i*4 +: 4] >= 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_acc      = rx_valid & ~cs_n;
    assign w_busy     = (r_state == S_PAY1) || (r_state == S_PAY2);
    assign w_tmo      = (r_tmo == TIMEOUT);
    assign w_tick_val = bcd_inc(r_digits);

    // Host writes of the digits take priority over a coincident tick.
    assign w_dig_commit = w_acc &&
                          (((r_state == S_IDLE) && (rx_byte == 8'h04)) ||
                           (r_state == S_PAY2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'd0;
            r_p1     <= 8'h00;
            r_tmo    <= 16'd0;
            r_digits <= 16'h0000;
            r_colon  <= 2'b11;
            r_mode   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;

            if (r_mode && tick_1s && !w_dig_commit) begin
                r_digits <= w_tick_val;
            end

            // A byte that lands on the expiry cycle wins: it is accepted and
            // the counter restarts.
            if (w_acc || !w_busy) begin
                r_tmo <= 16'd0;
            end else begin
                r_tmo <= r_tmo + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        case (rx_byte)
                            8'h01, 8'h02, 8'h03: begin
                                r_op    <= rx_byte[1:0];
                                r_state <= S_PAY1;
                            end
                            8'h04: begin
                                r_digits <= 16'h0000;
                            end
                            default: begin
                                r_ferr  <= 1'b1;
                                r_state <= S_DISCARD;
                            end
                        endcase
                    end
                end
                S_PAY1: begin
                    if (w_acc) begin
                        if (r_op == 2'd1) begin
                            r_p1    <= rx_byte;
                            r_state <= S_PAY2;
                        end else begin
                            if (r_op == 2'd2) begin
                                r_colon <= rx_byte[1:0];
                            end else begin
                                r_mode <= rx_byte[0];
                            end
                            r_state <= S_IDLE;
                        end
                    end else if (cs_n || w_tmo) begin
                        r_ferr  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_PAY2: begin
                    if (w_acc) begin
                        r_digits <= {r_p1, rx_byte};
                        r_state  <= S_IDLE;
                    end else if (cs_n || w_tmo) begin
                        r_ferr  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (cs_n) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign digit0     = r_digits[3:0];
    assign digit1     = r_digits[7:4];
    assign digit2     = r_digits[11:8];
    assign digit3     = r_digits[15:12];
    assign colon      = r_colon;
    assign count_mode = r_mode;
    assign busy       = w_busy;
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_seg_cmd_ctrl.sv
// Purpose : directed self-checking bench for seg_cmd_ctrl (TIMEOUT = 8).
// Latency : inputs change 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_seg_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       cs_n;
    logic       tick_1s;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       count_mode;
    logic       busy;
    logic       frame_err;
    logic [15:0] dig;

    int checks;
    int failures;
    int ferr_cnt;

    assign dig = {digit3, digit2, digit1, digit0};

    seg_cmd_ctrl #(.TIMEOUT(16'd8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .cs_n       (cs_n),
        .tick_1s    (tick_1s),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .colon      (colon),
        .count_mode (count_mode),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with frame_err high, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        step();
        tick_1s = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tick_1s = 1'b0;
        step(); step();
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL reset_digits got %h expected 0000", dig); end
        checks++; if (colon !== 2'b11) begin failures++; $display("FAIL reset_colon got %b expected 11", colon); end
        checks++; if ({count_mode, busy, frame_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b expected 000", {count_mode, busy, frame_err}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_set_digits();
        int f0;
        f0 = ferr_cnt;
        cs_n = 1'b0;
        send_byte(8'h01);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL set_digits_busy got %b expected 1", busy); end
        send_byte(8'h12);
        send_byte(8'h34);
        checks++; if (dig !== 16'h1234) begin failures++; $display("FAIL set_digits_value got %h expected 1234", dig); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL set_digits_idle got %b expected 0", busy); end
        cs_n = 1'b1;
        step(); step();
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL set_digits_ferr got %0d expected %0d", ferr_cnt, f0); end
    endtask

    task automatic test_colon_mode();
        cs_n = 1'b0;
        send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h03); send_byte(8'h01);
        cs_n = 1'b1;
        step();
        checks++; if (colon !== 2'b01) begin failures++; $display("FAIL colon_value got %b expected 01", colon); end
        checks++; if (count_mode !== 1'b1) begin failures++; $display("FAIL mode_value got %b expected 1", count_mode); end
        pulse_tick(); pulse_tick(); pulse_tick();
        checks++; if (dig !== 16'h1237) begin failures++; $display("FAIL tick_count got %h expected 1237", dig); end
    endtask

    task automatic test_bcd_wrap();
        cs_n = 1'b0;
        send_byte(8'h01); send_byte(8'h99); send_byte(8'h98);
        // Increment visible one cycle after the tick cycle.
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
        checks++; if (dig !== 16'h9999) begin failures++; $display("FAIL bcd_9999 got %h expected 9999", dig); end
        step();
        pulse_tick();
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL bcd_wrap got %h expected 0000", dig); end
        send_byte(8'h01); send_byte(8'h0F); send_byte(8'h9F);
        pulse_tick();
        checks++; if (dig !== 16'h1000) begin failures++; $display("FAIL bcd_nibble got %h expected 1000", dig); end
        cs_n = 1'b1;
        step();
    endtask

    task automatic test_abort_cs();
        int f0;
        f0 = ferr_cnt;
        cs_n = 1'b0;
        send_byte(8'h01); send_byte(8'h56);
        cs_n = 1'b1;
        step();
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL abort_cs_pulse got %b expected 1", frame_err); end
        step(); step();
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL abort_cs_count got %0d expected %0d", ferr_cnt - f0, 1); end
        checks++; if (dig !== 16'h1000) begin failures++; $display("FAIL abort_cs_digits got %h expected 1000", dig); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_cs_busy got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        int f0;
        int first;
        f0 = ferr_cnt;
        first = -1;
        cs_n = 1'b0;
        send_byte(8'h01); send_byte(8'h56);
        // Counter reaches 8 eight cycles after 0x56; frame_err follows on the next edge.
        for (int k = 1; k <= 12; k++) begin
            step();
            if (frame_err === 1'b1 && first < 0) first = k;
        end
        checks++; if (first !== 9) begin failures++; $display("FAIL timeout_cycle got %0d expected 9", first); end
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL timeout_count got %0d expected 1", ferr_cnt - f0); end
        checks++; if (dig !== 16'h1000) begin failures++; $display("FAIL timeout_digits got %h expected 1000", dig); end
        // Byte arriving exactly on the expiry cycle is accepted.
        f0 = ferr_cnt;
        send_byte(8'h01);
        for (int k = 0; k < 8; k++) step();
        send_byte(8'h77);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_edge_busy got %b expected 1", busy); end
        send_byte(8'h88);
        checks++; if (dig !== 16'h7788) begin failures++; $display("FAIL timeout_edge_digits got %h expected 7788", dig); end
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL timeout_edge_ferr got %0d expected 0", ferr_cnt - f0); end
        cs_n = 1'b1;
        step();
    endtask

    task automatic test_illegal();
        int f0;
        f0 = ferr_cnt;
        cs_n = 1'b0;
        send_byte(8'h7E);
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        cs_n = 1'b1;
        step(); step();
        checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL illegal_count got %0d expected 1", ferr_cnt - f0); end
        checks++; if (dig !== 16'h7788) begin failures++; $display("FAIL illegal_digits got %h expected 7788", dig); end
        cs_n = 1'b0;
        send_byte(8'h04);
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL clear_digits got %h expected 0000", dig); end
        cs_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        cs_n = 1'b0;
        send_byte(8'h01); send_byte(8'h00);
        rx_valid = 1'b1; rx_byte = 8'h05; tick_1s = 1'b1;
        step();
        rx_valid = 1'b0; rx_byte = 8'h00; tick_1s = 1'b0;
        checks++; if (dig !== 16'h0005) begin failures++; $display("FAIL arb_digits got %h expected 0005", dig); end
        step();
        checks++; if (dig !== 16'h0005) begin failures++; $display("FAIL arb_hold got %h expected 0005", dig); end
        // A SET_COLON commit does not block the tick.
        send_byte(8'h02);
        rx_valid = 1'b1; rx_byte = 8'h00; tick_1s = 1'b1;
        step();
        rx_valid = 1'b0; tick_1s = 1'b0;
        checks++; if ({colon, dig} !== {2'b00, 16'h0006}) begin failures++; $display("FAIL arb_colon got %b/%h expected 00/0006", colon, dig); end
        cs_n = 1'b1;
        step();
        // Bytes outside a frame are ignored.
        send_byte(8'h04);
        checks++; if (dig !== 16'h0006) begin failures++; $display("FAIL cs_high_ignored got %h expected 0006", dig); end
    endtask

    task automatic test_rst_mid();
        int f0;
        cs_n = 1'b0;
        send_byte(8'h01); send_byte(8'h12);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got %b expected 1", busy); end
        f0 = ferr_cnt;
        rst = 1'b1;
        #1;
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL rst_mid_digits got %h expected 0000", dig); end
        checks++; if ({colon, count_mode, busy, frame_err} !== 5'b11000) begin failures++; $display("FAIL rst_mid_flags got %b expected 11000", {colon, count_mode, busy, frame_err}); end
        step();
        rst = 1'b0;
        cs_n = 1'b1;
        step(); step();
        checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL rst_mid_ferr got %0d expected 0", ferr_cnt - f0); end
        // Host mode ignores ticks.
        pulse_tick();
        checks++; if (dig !== 16'h0000) begin failures++; $display("FAIL host_tick got %h expected 0000", dig); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ferr_cnt = 0;
        test_reset();
        test_set_digits();
        test_colon_mode();
        test_bcd_wrap();
        test_abort_cs();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
